// File: rtl/ksa_pkg.sv
// Shared types for the RC4 key-search S-memory phase sequencer and its port mux.
package ksa_pkg;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef logic [3:0] phase_t;
    localparam phase_t PH_IDLE     = 4'd0;
    localparam phase_t PH_INIT_ST  = 4'd1;
    localparam phase_t PH_INIT_RUN = 4'd2;
    localparam phase_t PH_SHUF_ST  = 4'd3;
    localparam phase_t PH_SHUF_RUN = 4'd4;
    localparam phase_t PH_DEC_ST   = 4'd5;
    localparam phase_t PH_DEC_RUN  = 4'd6;
    localparam phase_t PH_DONE     = 4'd7;
    localparam phase_t PH_ABORT    = 4'd8;
    localparam phase_t PH_ERROR    = 4'd9;

    typedef struct packed {
        logic [S_ADDR_W-1:0] addr;
        logic [S_DATA_W-1:0] data;
        logic                wren;
    } s_mem_req_t;

    localparam logic [1:0] CL_INIT = 2'd0;
    localparam logic [1:0] CL_SHUF = 2'd1;
    localparam logic [1:0] CL_DEC  = 2'd2;

    function automatic logic is_run(input phase_t p);
        return (p == PH_INIT_RUN) || (p == PH_SHUF_RUN) || (p == PH_DEC_RUN);
    endfunction

    function automatic logic [1:0] client_of(input phase_t p);
        case (p)
            PH_SHUF_ST, PH_SHUF_RUN: return CL_SHUF;
            PH_DEC_ST, PH_DEC_RUN:   return CL_DEC;
            default:                 return CL_INIT;
        endcase
    endfunction
endpackage

// File: rtl/s_mem_port_mux.sv
// 3:1 select of S-memory requests by client index; an invalid grant drives an idle (all-zero) request.
module s_mem_port_mux
    import ksa_pkg::*;
(
    input  s_mem_req_t [2:0] req,
    input  logic [1:0]       sel,
    input  logic             valid,
    output s_mem_req_t       gnt
);
    always_comb begin
        gnt = '0;
        if (valid) begin
            case (sel)
                CL_INIT: gnt = req[CL_INIT];
                CL_SHUF: gnt = req[CL_SHUF];
                CL_DEC:  gnt = req[CL_DEC];
                default: gnt = '0;
            endcase
        end
    end
endmodule

// File: rtl/s_mem_phase_sequencer.sv
// Sequences INIT -> SHUFFLE -> DECRYPT ownership of the single-port S memory, with key-change restart
// and a per-phase watchdog.
//
// state    | meaning
// IDLE     | waiting for key_available
// INIT_ST  | start pulse to INIT client
// INIT_RUN | INIT owns memory, waiting for done_in[0]
// SHUF_ST  | start pulse to SHUFFLE client
// SHUF_RUN | SHUFFLE owns memory, waiting for done_in[1]
// DEC_ST   | start pulse to DECRYPT client
// DEC_RUN  | DECRYPT owns memory, waiting for done_in[2]
// DONE     | all phases complete, hold until key_changed
// ABORT    | abort pulse after key change, then restart or idle
// ERROR    | watchdog expired, hold until key_changed
module s_mem_phase_sequencer
    import ksa_pkg::*;
#(
    parameter int ADDR_W      = S_ADDR_W,
    parameter int DATA_W      = S_DATA_W,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   key_available,
    input  logic                   key_changed,
    output logic [2:0]             start_out,
    output logic                   abort_out,
    input  logic [2:0]             done_in,
    input  logic [2:0][ADDR_W-1:0] req_addr,
    input  logic [2:0][DATA_W-1:0] req_data,
    input  logic [2:0]             req_wren,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_wren,
    output logic [3:0]             phase,
    output logic                   busy,
    output logic                   all_done,
    output logic                   error
);
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    phase_t           state;
    phase_t           state_nx;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_inc;
    logic             wd_hit;
    logic             run_active;
    logic [1:0]       client;
    logic             done_cur;
    s_mem_req_t [2:0] req;
    s_mem_req_t       gnt;

    assign req = {req_addr[2], req_data[2], req_wren[2],
                  req_addr[1], req_data[1], req_wren[1],
                  req_addr[0], req_data[0], req_wren[0]};

    assign run_active = is_run(state);
    assign client     = client_of(state);
    assign done_cur   = done_in[client];
    assign wd_inc     = wd + 1'b1;
    // Expiry lands ERROR exactly TIMEOUT_CYC cycles after the X_ST cycle.
    assign wd_hit     = (wd_inc == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx = state;
        if (key_changed && state != PH_IDLE) begin
            state_nx = PH_ABORT;
        end else begin
            case (state)
                PH_IDLE:     if (key_available) state_nx = PH_INIT_ST;
                PH_INIT_ST:  state_nx = PH_INIT_RUN;
                PH_SHUF_ST:  state_nx = PH_SHUF_RUN;
                PH_DEC_ST:   state_nx = PH_DEC_RUN;
                PH_INIT_RUN: if (done_cur) state_nx = PH_SHUF_ST;
                             else if (wd_hit) state_nx = PH_ERROR;
                PH_SHUF_RUN: if (done_cur) state_nx = PH_DEC_ST;
                             else if (wd_hit) state_nx = PH_ERROR;
                PH_DEC_RUN:  if (done_cur) state_nx = PH_DONE;
                             else if (wd_hit) state_nx = PH_ERROR;
                PH_ABORT:    state_nx = key_available ? PH_INIT_ST : PH_IDLE;
                PH_DONE:     state_nx = PH_DONE;
                PH_ERROR:    state_nx = PH_ERROR;
                default:     state_nx = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state     <= PH_IDLE;
            wd        <= '0;
            start_out <= 3'b000;
            abort_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            wd        <= run_active ? wd_inc : '0;
            start_out <= {state_nx == PH_DEC_ST, state_nx == PH_SHUF_ST, state_nx == PH_INIT_ST};
            abort_out <= (state_nx == PH_ABORT) || (state_nx == PH_ERROR && state != PH_ERROR);
            error     <= (state_nx == PH_ERROR);
        end
    end

    s_mem_port_mux u_port_mux (
        .req   (req),
        .sel   (client),
        .valid (run_active),
        .gnt   (gnt)
    );

    assign mem_address = gnt.addr;
    assign mem_data    = gnt.data;
    assign mem_wren    = gnt.wren;
    assign phase       = state;
    assign busy        = (state >= PH_INIT_ST) && (state <= PH_DEC_RUN);
    assign all_done    = (state == PH_DONE);
endmodule
